// File: rtl/apb_master.sv
// APB3 initiator: decodes single-shot core requests into one-hot PSEL and runs IDLE/SETUP/ACCESS.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int          NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int          TIMEOUT = 64
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [4:0] NUM_SLV_W = 5'(NUM_SLV);

  state_e              state_q, state_d;
  logic [31:0]         paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                penable_q, penable_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [3:0]          req_idx;
  logic                addr_ok;
  logic [NUM_SLV-1:0]  psel_dec;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Since PSEL is one-hot in ACCESS, masking with it picks the addressed slave
  // without indexing by the 4-bit slot number.
  always_comb begin
    req_idx   = addr[15:12];
    addr_ok   = (addr[31:16] == BASE_HI) && ({1'b0, req_idx} < NUM_SLV_W);
    sel_ready = |(PREADY & psel_q);
    sel_rdata = '0;
    psel_dec  = '0;
    for (int n = 0; n < NUM_SLV; n++) begin
      psel_dec[n] = (req_idx == 4'(n));
      if (psel_q[n]) sel_rdata = sel_rdata | PRDATA[32*n +: 32];
    end
  end

  // NOTE: every next-state signal gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          if (addr_ok) begin
            state_d = SETUP;
            psel_d  = psel_dec;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          rdata_d   = pwrite_q ? 32'h0 : sel_rdata;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // A late PREADY on the limit cycle still counts as a normal completion.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: inputs change 1ns after each rising edge,
// outputs are checked at that point with immediate assertions.
module tb_apb_master;

  localparam int NUM_SLV = 4;

  logic                  PCLK = 1'b0;
  logic                  PRESET;
  logic                  transfer, write;
  logic [31:0]           addr, wdata;
  logic [31:0]           rdata;
  logic                  done, err, busy;
  logic [31:0]           PADDR, PWDATA;
  logic                  PWRITE, PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [NUM_SLV*32-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  int total  = 0;
  int passed = 0;

  apb_master #(.NUM_SLV(NUM_SLV), .BASE_HI(16'h1000), .TIMEOUT(64)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Checks the APB-side handshake and completion flags in one call.
  task automatic check_bus(input string tag, input logic [3:0] psel_e, input logic pen_e,
                           input logic done_e, input logic busy_e);
    check({tag, ".psel"},    32'(PSEL),    32'(psel_e));
    check({tag, ".penable"}, 32'(PENABLE), 32'(pen_e));
    check({tag, ".done"},    32'(done),    32'(done_e));
    check({tag, ".busy"},    32'(busy),    32'(busy_e));
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = d;
  endtask

  initial begin
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    PREADY   = '0;
    PRDATA   = '0;
    for (int n = 0; n < NUM_SLV; n++) PRDATA[32*n +: 32] = 32'hA5A5_0000 | 32'(n);
    #12;
    check_bus("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("reset.paddr",  PADDR,  32'h0);
    check("reset.pwdata", PWDATA, 32'h0);
    check("reset.pwrite", 32'(PWRITE), 32'h0);
    check("reset.rdata",  rdata,  32'h0);
    check("reset.err",    32'(err), 32'h0);
    step();
    PRESET = 1'b0;
    step();

    // Write to slave 3, ready in the first ACCESS cycle.
    PREADY = 4'b1000;
    request(1'b1, 32'h1000_3000, 32'h0000_1234);
    step();
    transfer = 1'b0;
    check_bus("wr.setup", 4'b1000, 1'b0, 1'b0, 1'b1);
    check("wr.paddr",  PADDR,  32'h1000_3000);
    check("wr.pwdata", PWDATA, 32'h0000_1234);
    check("wr.pwrite", 32'(PWRITE), 32'h1);
    step();
    check_bus("wr.access", 4'b1000, 1'b1, 1'b0, 1'b1);
    step();
    check_bus("wr.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("wr.err",   32'(err), 32'h0);
    check("wr.rdata", rdata, 32'h0);
    step();
    check("wr.done_width", 32'(done), 32'h0);

    // Read slave 1 with three wait cycles; slave 0 ready is ignored.
    PREADY = 4'b0001;
    PRDATA[32 +: 32] = 32'hDEAD_BEEF;
    request(1'b0, 32'h1000_1004, 32'hFFFF_FFFF);
    step();
    transfer = 1'b0;
    check_bus("rd.setup", 4'b0010, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 3; w++) begin
      step();
      check_bus($sformatf("rd.wait%0d", w), 4'b0010, 1'b1, 1'b0, 1'b1);
      check($sformatf("rd.wait%0d.paddr", w), PADDR, 32'h1000_1004);
      check($sformatf("rd.wait%0d.pwrite", w), 32'(PWRITE), 32'h0);
    end
    PREADY = 4'b0011;
    step();
    check_bus("rd.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("rd.rdata", rdata, 32'hDEAD_BEEF);
    check("rd.err",   32'(err), 32'h0);
    PREADY = 4'b0000;
    step();
    check_bus("rd.after", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rd.rdata_hold", rdata, 32'hDEAD_BEEF);

    // Invalid addresses: wrong upper half, then slot beyond NUM_SLV.
    PREADY = 4'b1111;
    request(1'b0, 32'h2000_0000, 32'h0);
    step();
    transfer = 1'b0;
    check_bus("bad_hi", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("bad_hi.err",   32'(err), 32'h1);
    check("bad_hi.rdata", rdata, 32'h0);
    step();
    check("bad_hi.done_width", 32'(done), 32'h0);
    check("bad_hi.psel", 32'(PSEL), 32'h0);
    request(1'b0, 32'h1000_5000, 32'h0);
    step();
    transfer = 1'b0;
    check_bus("bad_idx", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("bad_idx.err", 32'(err), 32'h1);
    step();
    check_bus("bad_idx.after", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("bad_idx.err_clear", 32'(err), 32'h0);

    // transfer during ACCESS is dropped; transfer in the done cycle is taken.
    PREADY = 4'b0000;
    request(1'b1, 32'h1000_0010, 32'h5555_0000);
    step();
    transfer = 1'b0;
    step();
    check_bus("busy.access", 4'b0001, 1'b1, 1'b0, 1'b1);
    request(1'b0, 32'h1000_2000, 32'h0);
    step();
    transfer = 1'b0;
    check_bus("busy.ignored", 4'b0001, 1'b1, 1'b0, 1'b1);
    check("busy.paddr", PADDR, 32'h1000_0010);
    PREADY = 4'b0001;
    step();
    check_bus("busy.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    request(1'b0, 32'h1000_2000, 32'h0);
    PREADY = 4'b0000;
    PRDATA[64 +: 32] = 32'hCAFE_0002;
    step();
    transfer = 1'b0;
    check_bus("b2b.setup", 4'b0100, 1'b0, 1'b0, 1'b1);
    check("b2b.paddr", PADDR, 32'h1000_2000);
    PREADY = 4'b0100;
    step();
    step();
    check_bus("b2b.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("b2b.rdata", rdata, 32'hCAFE_0002);

    // Reset during ACCESS of a read, then a clean transfer.
    PREADY = 4'b0000;
    PRDATA[96 +: 32] = 32'h3333_0003;
    request(1'b0, 32'h1000_3008, 32'h0);
    step();
    transfer = 1'b0;
    step();
    check_bus("rst.access", 4'b1000, 1'b1, 1'b0, 1'b1);
    #1 PRESET = 1'b1;
    PREADY = 4'b1000;
    #1;
    check_bus("rst.async", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst.paddr", PADDR, 32'h0);
    check("rst.rdata", rdata, 32'h0);
    step();
    PRESET = 1'b0;
    step();
    check_bus("rst.no_done", 4'b0000, 1'b0, 1'b0, 1'b0);
    request(1'b0, 32'h1000_3008, 32'h0);
    step();
    transfer = 1'b0;
    step();
    step();
    check_bus("rst.recover", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("rst.recover.rdata", rdata, 32'h3333_0003);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave 2 never ready: timeout after 64 ACCESS cycles.
    PREADY = 4'b1011;
    request(1'b0, 32'h1000_2000, 32'h0);
    step();
    transfer = 1'b0;
    step();
    for (int c = 1; c < 64; c++) step();
    check_bus("to.last_access", 4'b0100, 1'b1, 1'b0, 1'b1);
    step();
    check_bus("to.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("to.err",   32'(err), 32'h1);
    check("to.rdata", rdata, 32'h0);
    step();
    // Same again, but PREADY arrives in the 64th ACCESS cycle.
    PREADY = 4'b0000;
    request(1'b0, 32'h1000_2000, 32'h0);
    step();
    transfer = 1'b0;
    step();
    for (int c = 1; c < 64; c++) step();
    PREADY = 4'b0100;
    step();
    check_bus("to_late.done", 4'b0000, 1'b0, 1'b1, 1'b0);
    check("to_late.err",   32'(err), 32'h0);
    check("to_late.rdata", rdata, 32'hCAFE_0002);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that converts single-shot register requests from the processor-side core into APB3 transfers towards the peripheral slaves (FND controller, GPIO, timer and others). It decodes the request address into one-hot slave selects, runs the IDLE → SETUP → ACCESS sequence, and waits for the selected slave's PREADY. It returns read data plus a one-cycle completion pulse to the requester. It sits between the core's bus port and all APB slave wrappers.

## Interface
Parameters:
- NUM_SLV, 4: number of slave select lines; legal range 1–16.
- BASE_HI, 16'h1000: required value of addr[31:16] for a valid peripheral access.
- TIMEOUT, 64: ACCESS-phase cycle limit; used only when the timeout feature is compiled in (see Configuration).

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESET  in  1  reset; asynchronous, active-high.
- transfer  in  1  request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  32  byte address; sampled with transfer.
- wdata  in  32  write data; sampled with transfer.
- rdata  out  32  read data; valid while done=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid while done=1.
- busy  out  1  high whenever state ≠ IDLE.
- PADDR  out  32  APB address (latched addr).
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB access-phase flag.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  NUM_SLV×32  packed slave read data; slave n uses bits [32n+31:32n].
- PREADY  in  NUM_SLV  per-slave ready.

## Operation
- Address decode: idx = addr[15:12]. The address is valid iff addr[31:16] == BASE_HI and idx < NUM_SLV.
- State machine: IDLE, SETUP, ACCESS; registered state.
- IDLE, transfer=1:
  - Latch addr, write and wdata into PADDR, PWRITE and PWDATA.
  - Valid address: go to SETUP.
  - Invalid address: stay in IDLE. Next cycle done=1, err=1, rdata=0. No PSEL is asserted.
- SETUP: PSEL[idx]=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1.
  - The master samples only PREADY[idx]; other slaves' PREADY and PRDATA are ignored.
  - PREADY[idx]=1: go to IDLE. Register done=1, err=0, and rdata = PRDATA[idx] on a read, or rdata=0 on a write.
  - PREADY[idx]=0: stay in ACCESS, holding all APB outputs stable.
- In IDLE, PSEL=0 and PENABLE=0. PADDR, PWRITE and PWDATA hold their last values.
- transfer while busy=1 is ignored; no queuing. The requester must wait for done before issuing a new transfer.
- transfer asserted in the same cycle done=1 is accepted, because the state is already IDLE.
- rdata holds its value after done deasserts until the next completion.
- Reset values: state=IDLE; PADDR=0, PWDATA=0, PWRITE=0, PENABLE=0, PSEL=0; rdata=0, done=0, err=0, busy=0.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. No done pulse is issued for the aborted transfer.

## Timing
- Edge E0 samples transfer=1, giving SETUP in cycle 1. E1 gives ACCESS in cycle 2.
- If E2 samples PREADY[idx]=1, done=1 in cycle 3. This is the minimum latency: 3 edges from request to done.
- Slaves with registered PREADY (ready one cycle after PSEL&PENABLE) give 2 ACCESS cycles, so done arrives 4 edges after the request.
- An invalid address gives done in cycle 1 (1 edge).
- done is exactly one PCLK wide per accepted transfer.
- PSEL is one-hot or zero at all times. PENABLE=1 only in ACCESS.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without PREADY[idx].
  - When the count reaches TIMEOUT-1 with PREADY[idx] still 0, the master goes to IDLE and issues done=1, err=1, rdata=0.
  - PREADY[idx] arriving on that same edge wins: normal completion with err=0.
- APB_MASTER_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely, and err is set only for invalid addresses.

## Test plan
- Write 0x0000_1234 to 0x1000_3000 with the slave 3 model ready after 1 ACCESS cycle → PSEL=4'b1000 with PENABLE 0 then 1, PWDATA=0x1234, done high in cycle 3, err=0.
- Read 0x1000_1004 with slave 1 returning PRDATA=0xDEAD_BEEF after 3 wait cycles → APB signals stable throughout ACCESS, rdata=0xDEADBEEF with done, busy low after.
- Read 0x2000_0000 (bad BASE_HI), then 0x1000_5000 (idx ≥ NUM_SLV) → PSEL stays 0, done=1 and err=1 one cycle after each request, rdata=0.
- transfer pulsed during ACCESS, then again in the done cycle → first pulse ignored with no extra PSEL; second pulse starts SETUP on the next cycle.
- Assert PRESET during ACCESS of a read → all outputs 0 immediately, no done, and the next transfer completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT=64, slave 2 never ready → done=1, err=1 after 64 ACCESS cycles. A repeat with PREADY arriving on cycle 64 gives err=0.
